bloom_filter_unit: RTL

// - Responder side of the custom-instruction Bloom path: accepts INSERT / CHECK / CLEAR commands

---
 rtl/bloom_pkg.sv | 34 +++
 rtl/bloom_hash.sv | 19 +
 rtl/bloom_filter_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bloom_pkg.sv
// Shared types and constants for the Bloom filter custom-op responder.
//   bloom_op_e    : command encoding driven by the custom-op decoder
//   bloom_state_e : control FSM states of bloom_filter_unit
//   BLOOM_SEED    : per-hash seeds XORed into the key before mixing
//   BLOOM_MULT    : multiplicative mixing constant
package bloom_pkg;

   typedef enum logic [1:0] {
      BLOOM_INSERT  = 2'b00,
      BLOOM_CHECK   = 2'b01,
      BLOOM_CLEAR   = 2'b10,
      BLOOM_ILLEGAL = 2'b11
   } bloom_op_e;

   typedef enum logic [2:0] {
      IDLE,
      HASH,
      PROBE,
      CLEAR,
      RESP
   } bloom_state_e;

   localparam logic [31:0] BLOOM_SEED [0:3] = '{
      32'h0000_0000, 32'h5BD1_E995, 32'hC2B2_AE35, 32'h27D4_EB2F
   };

   localparam logic [31:0] BLOOM_MULT = 32'h9E37_79B1;

   // Insert counter holds at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bloom_hash.sv
// One Bloom hash: multiplicative mix of the seeded key, top IDX_W bits
// of the 32-bit product select a bit in the array.
//   i_key32 : zero-extended key
//   i_seed  : per-hash seed
//   o_idx   : bit index into the NUM_BITS array
module bloom_hash import bloom_pkg::*; #(
   parameter int IDX_W = 8
) (
   input  logic [31:0]      i_key32,
   input  logic [31:0]      i_seed,
   output logic [IDX_W-1:0] o_idx
);

   logic [31:0] w_prod;

   assign w_prod = (i_key32 ^ i_seed) * BLOOM_MULT;
   assign o_idx  = w_prod[31 -: IDX_W];

endmodule

// File: rtl/bloom_filter_unit.sv
// Bloom filter responder for the custom-instruction path. Executes INSERT,
// CHECK and CLEAR on a word-organised flop array, one word access per cycle.
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   req_valid_i/req_ready_o    : command handshake (ready only in IDLE)
//   req_op_i, req_key_i        : command and key (RS1)
//   rsp_valid_o/rsp_ready_i    : response handshake to writeback
//   rsp_match_o, rsp_err_o     : CHECK result, illegal-op flag
//   rsp_count_o                : saturating inserts since last clear/reset
//
// state | meaning
// IDLE  | waiting for a command, req_ready_o high
// HASH  | register the NUM_HASH bit indices of the latched key
// PROBE | one hash per cycle: set bit (INSERT) or accumulate match (CHECK)
// CLEAR | zero one array word per cycle
// RESP  | hold response until writeback accepts it
module bloom_filter_unit import bloom_pkg::*; #(
   parameter int NUM_WORDS = 8,
   parameter int NUM_HASH  = 2,
   parameter int KEY_W     = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_op_i,
   input  logic [KEY_W-1:0] req_key_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             rsp_match_o,
   output logic             rsp_err_o,
   output logic [15:0]      rsp_count_o
);

   localparam int NUM_BITS = 32 * NUM_WORDS;
   localparam int IDX_W    = $clog2(NUM_BITS);
   localparam int WW       = IDX_W - 5;
   // One step counter serves both the hash sequence and the clear sweep.
   localparam int STEP_W   = (WW > 2) ? WW : 2;

   bloom_state_e      r_state;
   bloom_op_e         r_op;
   logic [31:0]       r_key32;
   logic [IDX_W-1:0]  r_idx [NUM_HASH];
   logic [STEP_W-1:0] r_step;
   logic              r_match_acc;
   logic [31:0]       r_array [NUM_WORDS];
   logic              r_rsp_valid;
   logic              r_rsp_match;
   logic              r_rsp_err;
   logic [15:0]       r_count;

   logic [IDX_W-1:0]  w_hash_idx [NUM_HASH];
   logic [IDX_W-1:0]  w_cur_idx;
   logic [WW-1:0]     w_word;
   logic [4:0]        w_bit;
   logic              w_bit_val;
   logic              w_probe_last;
   logic              w_clear_last;

   for (genvar j = 0; j < NUM_HASH; j++) begin : g_hash
      bloom_hash #(.IDX_W(IDX_W)) u_hash (
         .i_key32 (r_key32),
         .i_seed  (BLOOM_SEED[j]),
         .o_idx   (w_hash_idx[j])
      );
   end

   always_comb begin
      w_cur_idx = '0;
      for (int j = 0; j < NUM_HASH; j++) begin
         if (r_step == STEP_W'(j)) w_cur_idx = r_idx[j];
      end
   end

   assign w_word       = w_cur_idx[IDX_W-1:5];
   assign w_bit        = w_cur_idx[4:0];
   assign w_bit_val    = r_array[w_word][w_bit];
   assign w_probe_last = (r_step == STEP_W'(NUM_HASH - 1));
   assign w_clear_last = (r_step == STEP_W'(NUM_WORDS - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_op        <= BLOOM_INSERT;
         r_key32     <= '0;
         r_step      <= '0;
         r_match_acc <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_match <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_count     <= '0;
         for (int j = 0; j < NUM_HASH; j++) r_idx[j] <= '0;
         for (int w = 0; w < NUM_WORDS; w++) r_array[w] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid_i) begin
                  r_op        <= bloom_op_e'(req_op_i);
                  r_key32     <= 32'(req_key_i);
                  r_step      <= '0;
                  r_match_acc <= 1'b1;
                  case (bloom_op_e'(req_op_i))
                     BLOOM_INSERT, BLOOM_CHECK: r_state <= HASH;
                     BLOOM_CLEAR:               r_state <= CLEAR;
                     default: begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_match <= 1'b0;
                        r_rsp_err   <= 1'b1;
                     end
                  endcase
               end
            end
            HASH: begin
               for (int j = 0; j < NUM_HASH; j++) r_idx[j] <= w_hash_idx[j];
               r_state <= PROBE;
            end
            PROBE: begin
               // Read-modify-write per probe so two hashes in one word both stick.
               if (r_op == BLOOM_INSERT)
                  r_array[w_word] <= r_array[w_word] | (32'd1 << w_bit);
               r_match_acc <= r_match_acc & w_bit_val;
               if (w_probe_last) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_match <= (r_op == BLOOM_CHECK) ? (r_match_acc & w_bit_val) : 1'b0;
                  if (r_op == BLOOM_INSERT) r_count <= sat_inc16(r_count);
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            CLEAR: begin
               r_array[r_step[WW-1:0]] <= '0;
               if (w_clear_last) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_match <= 1'b0;
                  r_count     <= '0;
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready_o = (r_state == IDLE);
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_match_o = r_rsp_match;
   assign rsp_err_o   = r_rsp_err;
   assign rsp_count_o = r_count;

endmodule
